// File: rtl/sram_bist_pkg.sv
// Shared types, patterns and March C- element table for the SRAM BIST.
// Imported by sram_march_bist and sram_bist_chk.
package sram_bist_pkg;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;

   typedef logic [2:0] pat_t;
   localparam pat_t PAT_0 = 3'd0;
   localparam pat_t PAT_1 = 3'd1;
   localparam pat_t PAT_A = 3'd2;
   localparam pat_t PAT_B = 3'd3;
   localparam pat_t PAT_M = 3'd4;

   localparam logic [31:0] P0 = 32'h0000_0000;
   localparam logic [31:0] P1 = 32'hFFFF_FFFF;
   localparam logic [31:0] PA = 32'hA5A5_A5A5;
   localparam logic [31:0] PB = 32'h5A5A_5A5A;
   localparam logic [31:0] PM = 32'hA55A_A55A;

   // half = strobe 0101 (even bytes only), else all ones
   typedef struct packed {
      logic wr;
      pat_t pat;
      logic half;
   } op_t;

   localparam logic [2:0] EL_LAST = 3'd6;

   function automatic op_t mk_op(
      logic wr,
      pat_t pat,
      logic half
   );
      op_t o;
      o.wr   = wr;
      o.pat  = pat;
      o.half = half;
      return o;
   endfunction

   // Element table: op list indexed by element and op slot
   function automatic op_t el_op(
      logic [2:0] el,
      logic [1:0] idx
   );
      op_t o;
      o = mk_op(1'b0, PAT_0, 1'b0);
      case ({el, idx})
         5'b000_00: o = mk_op(1'b1, PAT_0, 1'b0);
         5'b001_00: o = mk_op(1'b0, PAT_0, 1'b0);
         5'b001_01: o = mk_op(1'b1, PAT_1, 1'b0);
         5'b010_00: o = mk_op(1'b0, PAT_1, 1'b0);
         5'b010_01: o = mk_op(1'b1, PAT_0, 1'b0);
         5'b011_00: o = mk_op(1'b0, PAT_0, 1'b0);
         5'b011_01: o = mk_op(1'b1, PAT_1, 1'b0);
         5'b100_00: o = mk_op(1'b0, PAT_1, 1'b0);
         5'b100_01: o = mk_op(1'b1, PAT_0, 1'b0);
         5'b101_00: o = mk_op(1'b0, PAT_0, 1'b0);
         5'b110_00: o = mk_op(1'b1, PAT_A, 1'b0);
         5'b110_01: o = mk_op(1'b1, PAT_B, 1'b1);
         5'b110_10: o = mk_op(1'b0, PAT_M, 1'b0);
         default:   o = mk_op(1'b0, PAT_0, 1'b0);
      endcase
      return o;
   endfunction

   // Index of the last op slot of an element (op count - 1)
   function automatic logic [1:0] el_last_op(logic [2:0] el);
      case (el)
         3'd1, 3'd2, 3'd3, 3'd4: return 2'd1;
         3'd6:                   return 2'd2;
         default:                return 2'd0;
      endcase
   endfunction

   function automatic logic el_down(logic [2:0] el);
      return (el == 3'd3) || (el == 3'd4);
   endfunction

   // One byte of a pattern; PM alternates PB/PA bytes from byte 0
   function automatic logic [7:0] pat_byte(
      pat_t p,
      logic odd
   );
      case (p)
         PAT_1:   return P1[7:0];
         PAT_A:   return PA[7:0];
         PAT_B:   return PB[7:0];
         PAT_M:   return odd ? PM[15:8] : PM[7:0];
         default: return P0[7:0];
      endcase
   endfunction

endpackage

// File: rtl/sram_bist_chk.sv
// Read-check stage: registers expected data/address of a read, compares with
// io_q a cycle later, keeps saturating err_cnt and the first-fail capture.
// Ports: clock/reset, clr (new run), rd_vld/rd_adr/rd_exp (read issued now),
// io_q, mis (mismatch this cycle), err_cnt, fail_adr/fail_exp/fail_got.
module sram_bist_chk
   import sram_bist_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              rd_vld,
   input  logic [ADDR_W-1:0] rd_adr,
   input  logic [DATA_W-1:0] rd_exp,
   input  logic [DATA_W-1:0] io_q,
   output logic              mis,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] fail_adr,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_got
);

   logic              vld_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] exp_q;

   assign mis = vld_q && (io_q != exp_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q    <= 1'b0;
         adr_q    <= '0;
         exp_q    <= '0;
         err_cnt  <= '0;
         fail_adr <= '0;
         fail_exp <= '0;
         fail_got <= '0;
      end else begin
         vld_q <= rd_vld;
         adr_q <= rd_adr;
         exp_q <= rd_exp;
         if (clr) begin
            err_cnt  <= '0;
            fail_adr <= '0;
            fail_exp <= '0;
            fail_got <= '0;
         end else if (mis) begin
            if (err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 1'b1;
            // err_cnt never returns to 0 mid-run, so this is the first error
            if (err_cnt == '0) begin
               fail_adr <= adr_q;
               fail_exp <= exp_q;
               fail_got <= io_q;
            end
         end
      end
   end

endmodule

// File: rtl/sram_march_bist.sv
// March C- plus byte-strobe BIST initiator driving a single-port SRAM.
// Ports: clock/reset, start, busy/done/pass, err_cnt, fail_adr/exp/got,
// SRAM side io_cen/io_wen (active-low), io_adr, io_d, io_wstrb, io_q.
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_cnt,
   output logic [ADDR_W-1:0]   fail_adr,
   output logic [DATA_W-1:0]   fail_exp,
   output logic [DATA_W-1:0]   fail_got,
   output logic                io_cen,
   output logic                io_wen,
   output logic [ADDR_W-1:0]   io_adr,
   output logic [DATA_W-1:0]   io_d,
   output logic [DATA_W/8-1:0] io_wstrb,
   input  logic [DATA_W-1:0]   io_q
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W-1:0] ADR_MAX = '1;

   state_t            state;
   logic [2:0]        el;
   logic [1:0]        oi;
   logic [ADDR_W-1:0] adr;

   op_t               op;
   logic [DATA_W-1:0] pat_w;
   logic [NB-1:0]     strb_w;
   logic              go;
   logic              run;
   logic              wr;
   logic              down;
   logic              last_op;
   logic              last_adr;
   logic              mis;

   assign go       = start && (state == IDLE || state == DONE);
   assign run      = state == RUN;
   assign op       = el_op(el, oi);
   assign wr       = run && op.wr;
   assign down     = el_down(el);
   assign last_op  = oi == el_last_op(el);
   assign last_adr = down ? (adr == '0) : (adr == ADR_MAX);

   always_comb begin
      pat_w  = '0;
      strb_w = '0;
      for (int b = 0; b < NB; b++) begin
         pat_w[8*b +: 8] = pat_byte(op.pat, b[0]);
         strb_w[b]       = !(op.half && b[0]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         el    <= '0;
         oi    <= '0;
         adr   <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (go) begin
                  state <= RUN;
                  el    <= '0;
                  oi    <= '0;
                  adr   <= '0;
               end
            end
            RUN: begin
               if (STOP_ON_FAIL != 0 && mis) begin
                  state <= DRAIN;
               end else if (!last_op) begin
                  oi <= oi + 1'b1;
               end else begin
                  oi <= '0;
                  if (!last_adr)
                     adr <= down ? adr - 1'b1 : adr + 1'b1;
                  else if (el == EL_LAST)
                     state <= DRAIN;
                  else begin
                     // explicit wrap: next element picks its own start
                     el  <= el + 1'b1;
                     adr <= el_down(el + 1'b1) ? ADR_MAX : '0;
                  end
               end
            end
            DRAIN: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   assign io_cen   = !run;
   assign io_wen   = !wr;
   assign io_adr   = run ? adr : '0;
   assign io_d     = wr ? pat_w : '0;
   assign io_wstrb = wr ? strb_w : '0;

   assign busy = run || state == DRAIN;
   assign done = state == DONE;
   assign pass = done && err_cnt == '0;

   sram_bist_chk #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_chk (
      .clock    (clock),
      .reset    (reset),
      .clr      (go),
      .rd_vld   (run && !op.wr),
      .rd_adr   (adr),
      .rd_exp   (pat_w),
      .io_q     (io_q),
      .mis      (mis),
      .err_cnt  (err_cnt),
      .fail_adr (fail_adr),
      .fail_exp (fail_exp),
      .fail_got (fail_got)
   );

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist with two behavioural SRAMs:
// dut1 (STOP_ON_FAIL=0) and dut2 (STOP_ON_FAIL=1).
module tb_sram_march_bist;

   logic clock  = 1'b0;
   logic reset  = 1'b1;
   logic start1 = 1'b0;
   logic start2 = 1'b0;
   int   cyc    = 0;
   int   tests  = 0;
   int   fails  = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   logic        busy1, done1, pass1, cen1, wen1;
   logic [15:0] err1;
   logic [7:0]  fa1, adr1;
   logic [31:0] fe1, fg1, d1, q1;
   logic [3:0]  ws1;

   logic        busy2, done2, pass2, cen2, wen2;
   logic [15:0] err2;
   logic [7:0]  fa2, adr2;
   logic [31:0] fe2, fg2, d2, q2;
   logic [3:0]  ws2;

   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];
   logic inj1 = 1'b0;
   logic inj2 = 1'b0;
   logic ign1 = 1'b0;

   sram_march_bist #(.ADDR_W(8), .DATA_W(32), .STOP_ON_FAIL(0)) dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .fail_adr(fa1), .fail_exp(fe1), .fail_got(fg1),
      .io_cen(cen1), .io_wen(wen1), .io_adr(adr1),
      .io_d(d1), .io_wstrb(ws1), .io_q(q1)
   );

   sram_march_bist #(.ADDR_W(8), .DATA_W(32), .STOP_ON_FAIL(1)) dut2 (
      .clock(clock), .reset(reset), .start(start2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
      .fail_adr(fa2), .fail_exp(fe2), .fail_got(fg2),
      .io_cen(cen2), .io_wen(wen2), .io_adr(adr2),
      .io_d(d2), .io_wstrb(ws2), .io_q(q2)
   );

   // SRAM models: registered read data, byte strobes (ign1 = model bug)
   always @(posedge clock) begin
      if (inj1) mem1[8'h25] <= 32'h0000_0001;
      if (!cen1) begin
         if (!wen1) begin
            for (int b = 0; b < 4; b++)
               if (ws1[b] || ign1) mem1[adr1][8*b +: 8] <= d1[8*b +: 8];
         end else q1 <= mem1[adr1];
      end
   end

   always @(posedge clock) begin
      if (inj2) mem2[8'h25] <= 32'h0000_0001;
      if (!cen2) begin
         if (!wen2) begin
            for (int b = 0; b < 4; b++)
               if (ws2[b]) mem2[adr2][8*b +: 8] <= d2[8*b +: 8];
         end else q2 <= mem2[adr2];
      end
   end

   typedef struct {
      int          c0;
      int          lat;
      logic        pass;
      logic [15:0] err;
      logic [7:0]  fa;
      logic [31:0] fe;
      logic [31:0] fg;
   } res_t;

   res_t sb1[$];
   res_t sb2[$];

   function automatic res_t mk(int c0, int lat, logic p, logic [15:0] e,
                               logic [7:0] fa, logic [31:0] fe,
                               logic [31:0] fg);
      res_t r;
      r.c0 = c0; r.lat = lat; r.pass = p; r.err = e;
      r.fa = fa; r.fe = fe; r.fg = fg;
      return r;
   endfunction

   task automatic check(string name, logic [95:0] got, logic [95:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic cmp(string t, res_t e, int lat, logic p, logic [15:0] err,
                      logic [7:0] fa, logic [31:0] fe, logic [31:0] fg);
      check({t, " done cycle"}, lat, e.lat);
      check({t, " pass"}, p, e.pass);
      check({t, " err_cnt"}, err, e.err);
      check({t, " fail_adr"}, fa, e.fa);
      check({t, " fail_exp"}, fe, e.fe);
      check({t, " fail_got"}, fg, e.fg);
   endtask

   task automatic chk_rst(string t, logic [4:0] ctl, logic [43:0] bus,
                          logic [87:0] res);
      check({t, " cen/wen/busy/done/pass"}, ctl, 5'b11000);
      check({t, " adr/d/wstrb"}, bus, 0);
      check({t, " err/fail"}, res, 0);
   endtask

   // Monitor: pops the expected result when a DUT raises done
   logic dp1 = 1'b0;
   logic dp2 = 1'b0;
   initial begin
      res_t e;
      forever begin
         @(negedge clock);
         if (done1 && !dp1) begin
            if (sb1.size() == 0)
               check("dut1 scoreboard depth", sb1.size(), 1);
            else begin
               e = sb1.pop_front();
               cmp("dut1", e, cyc - e.c0, pass1, err1, fa1, fe1, fg1);
            end
         end
         if (done2 && !dp2) begin
            if (sb2.size() == 0)
               check("dut2 scoreboard depth", sb2.size(), 1);
            else begin
               e = sb2.pop_front();
               cmp("dut2", e, cyc - e.c0, pass2, err2, fa2, fe2, fg2);
            end
         end
         dp1 = done1;
         dp2 = done2;
      end
   end

   task automatic to_cyc(int n);
      while (cyc < n) @(negedge clock);
   endtask

   // Called at a negedge; returns at the negedge of op cycle 1
   task automatic pulse(int w, output int c0);
      if (w == 1) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clock);
      start1 = 1'b0;
      start2 = 1'b0;
      c0 = cyc;
   endtask

   task automatic wait_done(int w, int c0);
      while (!(w == 1 ? done1 : done2) && cyc < c0 + 4000)
         @(negedge clock);
      check("run completes in budget", (w == 1 ? done1 : done2), 1);
   endtask

   initial begin
      int c0;
      repeat (3) @(negedge clock);
      chk_rst("reset dut1", {cen1, wen1, busy1, done1, pass1},
              {adr1, d1, ws1}, {err1, fa1, fe1, fg1});
      chk_rst("reset dut2", {cen2, wen2, busy2, done2, pass2},
              {adr2, d2, ws2}, {err2, fa2, fe2, fg2});
      reset = 1'b0;
      @(negedge clock);

      // A: clean run, a stray start mid-run, op-level spot checks
      pulse(1, c0);
      sb1.push_back(mk(c0, 3329, 1'b1, 16'd0, 8'h00, 32'h0, 32'h0));
      check("A op1 cen/wen/busy", {cen1, wen1, busy1}, 3'b001);
      check("A op1 adr/d/wstrb", {adr1, d1, ws1}, {8'h00, 32'h0, 4'hF});
      to_cyc(c0 + 499);
      start1 = 1'b1;
      @(negedge clock);
      start1 = 1'b0;
      check("A start in RUN ignored", {busy1, wen1, adr1}, {2'b11, 8'h7A});
      to_cyc(c0 + 1280);
      check("A M3 first op", {cen1, wen1, adr1, d1, ws1},
            {2'b01, 8'hFF, 32'h0, 4'h0});
      to_cyc(c0 + 2561);
      check("A M6 strobed write", {wen1, adr1, d1, ws1},
            {1'b0, 8'h00, 32'h5A5A_5A5A, 4'b0101});
      to_cyc(c0 + 2562);
      check("A M6 read", {wen1, adr1, d1, ws1},
            {1'b1, 8'h00, 32'h0, 4'h0});
      wait_done(1, c0);

      // B: mem[0x25] corrupted after M0
      pulse(1, c0);
      sb1.push_back(mk(c0, 3329, 1'b0, 16'd1, 8'h25, 32'h0, 32'h1));
      to_cyc(c0 + 256);
      inj1 = 1'b1;
      @(negedge clock);
      inj1 = 1'b0;
      wait_done(1, c0);

      // C: SRAM ignores byte strobes
      ign1 = 1'b1;
      pulse(1, c0);
      sb1.push_back(mk(c0, 3329, 1'b0, 16'd256, 8'h00,
                       32'hA55A_A55A, 32'h5A5A_5A5A));
      wait_done(1, c0);

      // D: start from DONE clears results and restarts
      ign1 = 1'b0;
      pulse(1, c0);
      check("D restart clears", {done1, busy1, err1}, {2'b01, 16'h0});
      sb1.push_back(mk(c0, 3329, 1'b1, 16'd0, 8'h00, 32'h0, 32'h0));
      wait_done(1, c0);

      // E: reset at op cycle 1000, then F: fresh clean run
      pulse(1, c0);
      to_cyc(c0 + 999);
      reset = 1'b1;
      @(negedge clock);
      chk_rst("E mid-run reset", {cen1, wen1, busy1, done1, pass1},
              {adr1, d1, ws1}, {err1, fa1, fe1, fg1});
      reset = 1'b0;
      @(negedge clock);
      pulse(1, c0);
      sb1.push_back(mk(c0, 3329, 1'b1, 16'd0, 8'h00, 32'h0, 32'h0));
      wait_done(1, c0);

      // G: STOP_ON_FAIL with the 0x25 fault
      pulse(2, c0);
      sb2.push_back(mk(c0, 333, 1'b0, 16'd1, 8'h25, 32'h0, 32'h1));
      to_cyc(c0 + 256);
      inj2 = 1'b1;
      @(negedge clock);
      inj2 = 1'b0;
      to_cyc(c0 + 331);
      check("G cen in mismatch cycle", cen2, 1'b0);
      @(negedge clock);
      check("G cen after mismatch", cen2, 1'b1);
      wait_done(2, c0);

      repeat (2) @(negedge clock);
      check("dut1 scoreboard drained", sb1.size(), 0);
      check("dut2 scoreboard drained", sb2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test initiator for the 256x32 single-port SRAM model (`io_cen`/`io_wen` active-low, byte write strobes, one-cycle registered read data). On `start` it drives a March C- sequence plus a byte-strobe element onto the SRAM port and checks every read against the expected pattern. It reports pass/fail, the first failing access, and an error count. It replaces bench-driven random traffic for the memory regression and sits directly on the SRAM's `io_*` pins.

## Interface
- `ADDR_W`, 8, address width; depth is `2**ADDR_W`.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `STOP_ON_FAIL`, 0, if 1, end the run after the first mismatch.
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE.
- `busy`  out  1  high from the cycle after `start` until `done` rises.
- `done`  out  1  held high after run completion until the next `start` or `reset`.
- `pass`  out  1  valid while `done`; 1 means zero mismatches.
- `err_cnt`  out  16  mismatch count, saturating at 16'hFFFF.
- `fail_adr`  out  ADDR_W  address of the first mismatch.
- `fail_exp`  out  DATA_W  expected data at the first mismatch.
- `fail_got`  out  DATA_W  `io_q` value at the first mismatch.
- `io_cen`  out  1  SRAM chip enable, active-low.
- `io_wen`  out  1  SRAM write enable, active-low; 1 means read.
- `io_adr`  out  ADDR_W  SRAM address.
- `io_d`  out  DATA_W  SRAM write data.
- `io_wstrb`  out  DATA_W/8  byte write strobes.
- `io_q`  in  DATA_W  SRAM read data, valid the cycle after the read request.

## Operation
- Patterns: P0 = all zeros, P1 = all ones, PA = 0xA5A5A5A5, PB = 0x5A5A5A5A. PM = 0xA55AA55A (PA with strobe 0101 of PB merged in).
- Elements in fixed order. ⇑ is address 0 to 255; ⇓ is address 255 to 0.
  - M0 ⇑(w P0)
  - M1 ⇑(r P0, w P1)
  - M2 ⇑(r P1, w P0)
  - M3 ⇓(r P0, w P1)
  - M4 ⇓(r P1, w P0)
  - M5 ⇑(r P0)
  - M6 ⇑(w PA strobe 1111, w PB strobe 0101, r PM)
- All ops within one address are issued back-to-back, one op per cycle, with no idle cycles anywhere in the run.
- Writes in M0–M5 use strobe all-ones. Reads drive `io_wstrb` = 0 and `io_d` = 0.
- FSM states:
  - IDLE: waits for `start`.
  - RUN: issues ops.
  - DRAIN: one cycle to check the final read.
  - DONE: results held.
- Transitions: IDLE/DONE + `start` → RUN; RUN after the last M6 op → DRAIN → DONE. A new `start` clears `err_cnt`, `fail_*` and `pass`.
- `start` while in RUN or DRAIN is ignored.
- Check stage: a read issued in cycle t has its expected value and address registered, and is compared with `io_q` in cycle t+1.
  - On mismatch, `err_cnt` increments.
  - If this is the first error of the run, `fail_adr`, `fail_exp` and `fail_got` are captured and then frozen.
- With `STOP_ON_FAIL`=1, the first mismatch forces `io_cen` = 1 from the next cycle and the FSM goes to DONE via DRAIN. Any read issued in the mismatch cycle is still checked in DRAIN.
- Address counter wraps per element: 255→0 for ⇑, 0→255 for ⇓. The wrap selects the next element; the counter is never used modulo-implicitly.

## Timing
- Reset values: `io_cen`=1, `io_wen`=1, `io_adr`=0, `io_d`=0, `io_wstrb`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_*`=0. FSM = IDLE.
- `start` sampled high at edge E0 → first op (M0, addr 0) is driven in the cycle after E0, and `busy`=1 in that same cycle.
- Op-cycle count: 256 + 4×512 + 256 + 768 = 3328 cycles. DRAIN follows. `done`=1 and `busy`=0 from op cycle 3330, with `pass` valid in the same cycle.
- Outside RUN: `io_cen`=1 and `io_wen`=1.
- A read followed by a write to the same address in the next cycle is legal; the SRAM returns the pre-write data.
- `reset` asserted mid-run: all outputs take their reset values at the next edge, any in-flight read check is discarded, and no partial result is kept.

## Structure
- Package `sram_bist_pkg` holds:
  - `state_t`: IDLE, RUN, DRAIN, DONE.
  - `op_t`: read/write, pattern select, strobe.
  - Element table constants: op list, direction and op count per element.
  - Pattern constants P0, P1, PA, PB, PM.
- One sub-module, `sram_bist_chk`: the registered expected/address pipeline, the comparator, the saturating `err_cnt`, and first-fail capture.

## Test plan
- Fault-free SRAM, `start` pulsed once → `done` at op cycle 3330, `pass`=1, `err_cnt`=0, and the existing SRAM checker reports no error.
- Bench forces mem[0x25] = 0x00000001 after M0 completes → `pass`=0, `fail_adr`=0x25, `fail_exp`=0x00000000, `fail_got`=0x00000001, `err_cnt`≥1.
- SRAM model ignores `io_wstrb` (full-word write) → M6 reads 0x5A5A5A5A, `fail_exp`=0xA55AA55A, `err_cnt`=256.
- `STOP_ON_FAIL`=1 with the mem[0x25] fault → `io_cen` returns to 1 within 2 cycles of the first failing read, `err_cnt`=1, `done`=1.
- `reset` asserted at op cycle 1000 → all outputs at reset values the next cycle; a fresh `start` gives `pass`=1 after 3330 cycles.
- `start` pulsed again during RUN → ignored, with unchanged completion cycle. `start` in DONE → `done` drops and the run restarts with counters cleared.
